// File: rtl/riscy_pkg.sv
// Shared types and constants for the RISCY MIPS fetch path.
package riscy_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

    // FETCH: request outstanding, HOLD: IF/ID full and stalled, DRAIN: discard one stale response
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect decode, target mux with word alignment, and sequential PC+4.
module pc_next_sel
    import riscy_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        Branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    input  logic        Jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] target,
    output logic [31:0] pc_incr
);

    // A jump outranks a taken branch when both arrive together.
    assign redirect = Jump | (Branch & zero);
    assign target   = (Jump ? jump_target : branch_target) & WORD_ALIGN_MASK;
    assign pc_incr  = pc + 32'd4;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, instruction-memory req/valid handshake and the IF/ID register.
module instruction_fetch
    import riscy_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    input  logic        Jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        if_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_incr;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .Branch        (Branch),
        .zero          (zero),
        .branch_target (branch_target),
        .Jump          (Jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target),
        .pc_incr       (pc_incr)
    );

    assign imem_addr = pc;

    // imem_req is registered and raised exactly when the next state is FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC & WORD_ALIGN_MASK;
            imem_req    <= 1'b0;
            instruction <= NOP_INSTR;
            pc_plus4    <= '0;
            if_valid    <= 1'b0;
        end else if (redirect) begin
            pc          <= target;
            instruction <= NOP_INSTR;
            pc_plus4    <= '0;
            if_valid    <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (imem_req && !imem_valid) begin
                        state    <= DRAIN;
                        imem_req <= 1'b0;
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                DRAIN: begin
                    // A redirect while draining still owes exactly one response.
                    if (imem_valid) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state    <= DRAIN;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_req && imem_valid) begin
                        if (!stall || !if_valid) begin
                            instruction <= imem_rdata;
                            pc_plus4    <= pc_incr;
                            if_valid    <= 1'b1;
                            pc          <= pc_incr;
                            imem_req    <= 1'b1;
                        end else begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand sequences and a random run against a transaction model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, Branch, zero, Jump;
    logic [31:0] branch_target, jump_target;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, instruction, pc_plus4;
    logic        if_valid;

    logic        valid2;
    logic [31:0] rdata2;
    logic        req2;
    logic [31:0] addr2, instr2, pc4Two;
    logic        ifv2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .Branch        (Branch),
        .zero          (zero),
        .branch_target (branch_target),
        .Jump          (Jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_plus4      (pc_plus4),
        .if_valid      (if_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk           (clk),
        .reset         (reset),
        .stall         (1'b0),
        .Branch        (1'b0),
        .zero          (1'b0),
        .branch_target (32'h0),
        .Jump          (1'b0),
        .jump_target   (32'h0),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_valid    (valid2),
        .imem_rdata    (rdata2),
        .instruction   (instr2),
        .pc_plus4      (pc4Two),
        .if_valid      (ifv2)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rdata;
        logic        stall;
        logic        branch;
        logic        zero;
        logic        jump;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        expIfv;
    } vec_t;

    vec_t tbl[20];

    // Transaction-level reference state for the random run
    logic [31:0] mPc, mInstr, mPc4;
    logic        mIfv, mReq, mDiscard, mParked;
    logic        memBusy;
    int          memCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic [31:0] eInstr, input logic [31:0] ePc4, input logic eIfv);
        checkOutput({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, eReq});
        checkOutput({tag, " imem_addr"}, imem_addr, eAddr);
        checkOutput({tag, " instruction"}, instruction, eInstr);
        checkOutput({tag, " pc_plus4"}, pc_plus4, ePc4);
        checkOutput({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, eIfv});
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_valid    = v.valid;
        imem_rdata    = v.rdata;
        stall         = v.stall;
        Branch        = v.branch;
        zero          = v.zero;
        Jump          = v.jump;
        branch_target = v.target;
        jump_target   = v.target;
    endtask

    task automatic clearInputs();
        imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0; Branch = 1'b0; zero = 1'b0;
        Jump = 1'b0; branch_target = '0; jump_target = '0;
    endtask

    task automatic modelStep();
        logic        redir;
        logic [31:0] tgt;
        logic        wasReq;
        redir  = Jump | (Branch & zero);
        tgt    = (Jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        wasReq = mReq;
        if (imem_valid && mDiscard) mDiscard = 1'b0;
        if (redir) begin
            mPc = tgt; mInstr = 32'h0; mPc4 = 32'h0; mIfv = 1'b0; mParked = 1'b0;
            if (wasReq && !imem_valid) mDiscard = 1'b1;
            mReq = !mDiscard;
        end else if (wasReq && imem_valid) begin
            if (stall && mIfv) begin
                mParked = 1'b1; mReq = 1'b0;
            end else begin
                mInstr = imem_rdata; mPc = mPc + 32'd4; mPc4 = mPc; mIfv = 1'b1;
            end
        end else if (mParked) begin
            if (!stall) begin
                mParked = 1'b0; mReq = 1'b1;
            end
        end else if (!mDiscard) begin
            mReq = 1'b1;
        end
    endtask

    initial begin
        // valid, rdata, stall, br, zero, jump, target, req, addr, instr, pc4, ifv
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h0,         32'h0,   1'b0};
        tbl[1]  = '{1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'hA000_0000, 32'h4,   1'b1};
        tbl[2]  = '{1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'hA000_0004, 32'h8,   1'b1};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h100, 32'h0,         32'h0,   1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 32'h0,         32'h0,   1'b0};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 32'h0,         32'h0,   1'b0};
        tbl[6]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h0,         32'h0,   1'b0};
        tbl[7]  = '{1'b1, 32'hB000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  1'b1, 32'h104, 32'hB000_0100, 32'h104, 1'b1};
        tbl[8]  = '{1'b1, 32'hB000_0104, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40,  1'b1, 32'h40,  32'h0,         32'h0,   1'b0};
        tbl[9]  = '{1'b1, 32'hC000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[11] = '{1'b1, 32'hC000_0044, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  32'hC000_0040, 32'h44,  1'b1};
        tbl[15] = '{1'b1, 32'hC000_0044, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h48,  32'hC000_0044, 32'h48,  1'b1};
        tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h200, 32'h0,         32'h0,   1'b0};
        tbl[17] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h302, 1'b0, 32'h300, 32'h0,         32'h0,   1'b0};
        tbl[18] = '{1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 32'h0,         32'h0,   1'b0};
        tbl[19] = '{1'b1, 32'hD000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 32'hD000_0300, 32'h304, 1'b1};

        clearInputs();
        valid2 = 1'b0; rdata2 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkAll("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("wrap reset addr", addr2, 32'hFFFF_FFF8);
        reset = 1'b0;

        // Directed table: fetch stream, jump with drain, branch not/taken, stall and hold
        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkAll($sformatf("row%0d", i), tbl[i].expReq, tbl[i].expAddr,
                     tbl[i].expInstr, tbl[i].expPc4, tbl[i].expIfv);
        end
        clearInputs();

        // PC wrap from the top of the address space
        checkOutput("wrap req", {31'b0, req2}, 32'h1);
        checkOutput("wrap addr0", addr2, 32'hFFFF_FFF8);
        valid2 = 1'b1; rdata2 = 32'h1111_1111;
        @(negedge clk);
        checkOutput("wrap addr1", addr2, 32'hFFFF_FFFC);
        checkOutput("wrap pc4 1", pc4Two, 32'hFFFF_FFFC);
        checkOutput("wrap instr1", instr2, 32'h1111_1111);
        rdata2 = 32'h2222_2222;
        @(negedge clk);
        checkOutput("wrap addr2", addr2, 32'h0);
        checkOutput("wrap pc4 2", pc4Two, 32'h0);
        checkOutput("wrap instr2", instr2, 32'h2222_2222);
        checkOutput("wrap ifv", {31'b0, ifv2}, 32'h1);
        valid2 = 1'b0;

        // Asynchronous reset between edges with a request outstanding
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkAll("async reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        checkAll("late valid", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        checkAll("restart", 1'b1, 32'h4, 32'h1234_5678, 32'h4, 1'b1);
        clearInputs();

        // Random run against the transaction model
        reset = 1'b1;
        memBusy = 1'b0; memCnt = 0;
        repeat (2) @(negedge clk);
        mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0;
        mIfv = 1'b0; mReq = 1'b0; mDiscard = 1'b0; mParked = 1'b0;
        reset = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkAll($sformatf("rand%0d", cyc), mReq, mPc, mInstr, mPc4, mIfv);
            imem_valid = 1'b0;
            if (memBusy) begin
                if (memCnt <= 1) begin
                    imem_valid = 1'b1;
                    imem_rdata = $urandom;
                    memBusy    = 1'b0;
                end else begin
                    memCnt--;
                end
            end else if (imem_req) begin
                memBusy = 1'b1;
                memCnt  = $urandom_range(1, 4);
            end
            stall         = ($urandom_range(0, 3) == 0);
            Jump          = ($urandom_range(0, 19) == 0);
            Branch        = ($urandom_range(0, 9) == 0);
            zero          = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            jump_target   = $urandom;
        end
        clearInputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
